// File: rtl/spi_master_module_if.sv
// Byte-stream handshake between a host and spi_master_module.
//   iValid/iData/iLast : host offers a byte (MSB first on the wire) and marks frame end
//   oReady             : block accepts the offered byte this cycle
//   oData/oDone        : last received byte and its one-cycle update strobe
//   oBusy              : block is not idle
// master = host side, slave = spi_master_module side.
interface spi_master_module_if;
  logic       iValid;
  logic [7:0] iData;
  logic       iLast;
  logic       oReady;
  logic [7:0] oData;
  logic       oDone;
  logic       oBusy;

  modport master (output iValid, iData, iLast, input oReady, oData, oDone, oBusy);
  modport slave  (input iValid, iData, iLast, output oReady, oData, oDone, oBusy);
endinterface

// File: rtl/spi_master_module.sv
// SPI mode-0 master that frames a stream of bytes under one chip select.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : byte handshake (see spi_master_module_if)
//   ncs        : active-low chip select
//   sck        : SPI clock, idles low
//   mosi       : serial data out, MSB first, changes only while sck is low
//   miso       : serial data in, passed through a 2-flop synchroniser
module spi_master_module #(
  parameter int SCK_HALF = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_master_module_if.slave    bus,
  output logic                  ncs,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GAP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_lim;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic [7:0]  rx_nxt;
  logic [7:0]  data_r;
  logic        last;
  logic        armed;
  logic        done_r;
  logic        miso_p0, miso_p1;
  logic        ready, accept, cnt_end, sample, byte_end;

  // Per-state dwell length; IDLE/WAIT use 0 so cnt simply stays cleared there.
  always_comb begin
    cnt_lim = 8'd0;
    case (state)
      SETUP:   cnt_lim = 8'(CS_SETUP - 1);
      SHIFT:   cnt_lim = 8'(SCK_HALF - 1);
      HOLD:    cnt_lim = 8'(CS_HOLD - 1);
      GAP:     cnt_lim = 8'(CS_GAP - 1);
      default: cnt_lim = 8'd0;
    endcase
  end

  // armed keeps oReady low while in reset and releases it on the first edge after.
  // The oDone cycle is excluded so a completed byte is always visible before the next one is taken.
  assign ready    = armed && ((state == IDLE) || ((state == WAIT) && !done_r));
  assign accept   = bus.iValid && ready;
  assign cnt_end  = (cnt == cnt_lim);
  // miso is captured at the end of the first cycle sck is high.
  assign sample   = (state == SHIFT) && sck && (cnt == 8'd0);
  assign byte_end = (state == SHIFT) && sck && cnt_end && (bit_cnt == 3'd7);
  // With SCK_HALF=1 the last sample and the byte end share a cycle, so oData takes the merged value.
  assign rx_nxt   = sample ? {rx_sh[6:0], miso_p1} : rx_sh;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = SETUP;
      SETUP:   if (cnt_end)  state_nxt = SHIFT;
      SHIFT:   if (byte_end) state_nxt = last ? HOLD : WAIT;
      WAIT:    if (accept)   state_nxt = SHIFT;
      HOLD:    if (cnt_end)  state_nxt = GAP;
      GAP:     if (cnt_end)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      bit_cnt <= 3'd0;
      tx_sh   <= 8'd0;
      rx_sh   <= 8'd0;
      data_r  <= 8'd0;
      last    <= 1'b0;
      armed   <= 1'b0;
      done_r  <= 1'b0;
      miso_p0 <= 1'b0;
      miso_p1 <= 1'b0;
      ncs     <= 1'b1;
      sck     <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      // stage p0 -> p1: miso synchroniser
      miso_p0 <= miso;
      miso_p1 <= miso_p0;
      armed   <= 1'b1;
      state   <= state_nxt;
      done_r  <= 1'b0;
      rx_sh   <= rx_nxt;
      cnt     <= ((state != state_nxt) || cnt_end) ? 8'd0 : cnt + 8'd1;

      if (accept) begin
        tx_sh   <= bus.iData;
        last    <= bus.iLast;
        mosi    <= bus.iData[7];
        ncs     <= 1'b0;
        sck     <= 1'b0;
        bit_cnt <= 3'd0;
        rx_sh   <= 8'd0;
      end

      if ((state == SHIFT) && cnt_end) begin
        if (!sck) begin
          sck <= 1'b1;
        end else begin
          sck <= 1'b0;
          if (bit_cnt == 3'd7) begin
            done_r <= 1'b1;
            data_r <= rx_nxt;
          end else begin
            // next bit goes out on the falling edge
            bit_cnt <= bit_cnt + 3'd1;
            tx_sh   <= {tx_sh[6:0], 1'b0};
            mosi    <= tx_sh[6];
          end
        end
      end

      if ((state == HOLD) && cnt_end) begin
        ncs  <= 1'b1;
        mosi <= 1'b0;
      end
    end
  end

  assign bus.oReady = ready;
  assign bus.oData  = data_r;
  assign bus.oDone  = done_r;
  assign bus.oBusy  = (state != IDLE);

endmodule

// File: tb/tb_spi_master_module.sv
module tb_spi_master_module;
  localparam int H  = 2;
  localparam int S  = 2;
  localparam int CH = 2;
  localparam int CG = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic ncs, sck, mosi;
  logic miso_m = 1'b0;
  logic loop_en = 1'b0;
  wire  miso_w = loop_en ? mosi : miso_m;

  spi_master_module_if bus();

  spi_master_module #(.SCK_HALF(H), .CS_SETUP(S), .CS_HOLD(CH), .CS_GAP(CG)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .ncs(ncs), .sck(sck), .mosi(mosi), .miso(miso_w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, want);
    end
  endtask

  // Reference model: a frame is a timeline of setup, 16*H shift cycles per byte,
  // then wait (non-last) or hold+gap (last); outputs follow from cycle offsets.
  bit         act = 1'b0;
  bit         blast = 1'b0;
  int         ss = 0, done_c = 0, ready_at = 0;
  logic [7:0] b = 8'd0, sb = 8'd0, next_sb = 8'd0, odata_exp = 8'd0;
  int         acc_cnt = 0, rise_cnt = 0;

  // bench-side observations of the pins
  int         done_cnt = 0, sck_rise_cnt = 0, ncs_low_cyc = 0, ncs_rise_cnt = 0;
  int         hi_run = 0, last_hi_run = 0;
  logic [7:0] rec = 8'd0;
  logic       sck_q = 1'b0, ncs_q = 1'b1;

  always @(negedge clk) begin
    logic e_ncs, e_sck, e_mosi, e_done, e_ready, e_busy;
    bit   c_mosi;
    int   k;
    e_ncs = 1'b1; e_sck = 1'b0; e_mosi = 1'b0; e_done = 1'b0;
    e_ready = 1'b0; e_busy = 1'b0; c_mosi = 1'b0;
    if (!rst_n) begin
      act = 1'b0;
      ready_at = cyc + 2;
      odata_exp = 8'd0;
      c_mosi = 1'b1;
    end else begin
      if (act && blast && cyc >= done_c + CH + CG) begin
        act = 1'b0;
        ready_at = done_c + CH + CG;
      end
      e_busy = act;
      if (!act) begin
        e_ready = (cyc >= ready_at);
      end else begin
        e_ncs = 1'b0;
        c_mosi = 1'b1;
        if (cyc < ss) begin
          e_mosi = b[7];
        end else if (cyc < done_c) begin
          k = cyc - ss;
          e_sck  = (k % (2*H)) >= H;
          e_mosi = b[7 - k/(2*H)];
          if (k % (2*H) == H) rise_cnt++;
        end else begin
          e_mosi = b[0];
          e_done = (cyc == done_c);
          if (cyc == done_c) odata_exp = sb;
          if (blast) begin
            if (cyc >= done_c + CH) begin
              e_ncs = 1'b1;
              c_mosi = 1'b0;
            end
          end else begin
            e_ready = (cyc > done_c);
          end
        end
      end
    end

    chk("ncs",   32'(ncs),          32'(e_ncs));
    chk("sck",   32'(sck),          32'(e_sck));
    chk("done",  32'(bus.oDone),    32'(e_done));
    chk("ready", 32'(bus.oReady),   32'(e_ready));
    chk("busy",  32'(bus.oBusy),    32'(e_busy));
    chk("odata", 32'(bus.oData),    32'(odata_exp));
    if (c_mosi) chk("mosi", 32'(mosi), 32'(e_mosi));

    if (rst_n && bus.iValid && e_ready) begin
      if (!act) begin
        act = 1'b1;
        ss = cyc + 1 + S;
      end else begin
        ss = cyc + 1;
      end
      b = bus.iData;
      blast = bus.iLast;
      sb = loop_en ? bus.iData : next_sb;
      done_c = ss + 16*H;
      acc_cnt++;
    end

    // slave drives bit j through its low phase; the late high-phase cycle carries noise
    if (act && cyc >= ss && cyc < done_c) begin
      k = cyc - ss;
      if (k % (2*H) == 2*H - 1) miso_m = 1'($urandom);
      else                      miso_m = sb[7 - k/(2*H)];
    end else begin
      miso_m = 1'($urandom);
    end

    if (ncs === 1'b0) ncs_low_cyc++;
    if (sck && !sck_q && !ncs) begin
      sck_rise_cnt++;
      rec = {rec[6:0], mosi};
    end
    if (bus.oDone) done_cnt++;
    if (ncs && !ncs_q) ncs_rise_cnt++;
    if (ncs) hi_run++;
    else begin
      if (ncs_q) last_hi_run = hi_run;
      hi_run = 0;
    end
    sck_q = sck;
    ncs_q = ncs;
  end

  task automatic send(input logic [7:0] d, input bit last, input logic [7:0] s);
    int n0, g;
    bus.iValid = 1'b1;
    bus.iData  = d;
    bus.iLast  = last;
    next_sb    = s;
    n0 = acc_cnt;
    g = 0;
    while (acc_cnt == n0 && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    if (acc_cnt == n0) chk("accept_timeout", 32'(acc_cnt), 32'(n0 + 1));
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((act || cyc < ready_at) && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 1000) chk("idle_timeout", 32'(act), 32'(0));
  endtask

  initial begin
    int d_done, d_rise, d_low, d_nr, ok, r0, len;
    bus.iValid = 1'b0;
    bus.iData  = 8'd0;
    bus.iLast  = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ncs",  32'(ncs), 32'(1));
    chk("rst_odata", 32'(bus.oData), 32'(8'h00));
    @(posedge clk); #1;

    // single A5 byte, loopback
    loop_en = 1'b1;
    d_done = done_cnt; d_rise = sck_rise_cnt; d_low = ncs_low_cyc;
    send(8'hA5, 1'b1, 8'h00);
    bus.iValid = 1'b0;
    wait_idle();
    loop_en = 1'b0;
    chk("a5_pulses",  32'(sck_rise_cnt - d_rise), 32'(8));
    chk("a5_mosi",    32'(rec), 32'(8'hA5));
    chk("a5_odata",   32'(bus.oData), 32'(8'hA5));
    chk("a5_done",    32'(done_cnt - d_done), 32'(1));
    chk("a5_ncs_low", 32'(ncs_low_cyc - d_low), 32'(36));

    // 13-byte frame back to back
    d_done = done_cnt; d_nr = ncs_rise_cnt;
    send(8'h55, 1'b0, 8'($urandom));
    for (int i = 0; i < 12; i++) send(8'(i), i == 11, 8'($urandom));
    bus.iValid = 1'b0;
    wait_idle();
    chk("f13_done", 32'(done_cnt - d_done), 32'(13));
    chk("f13_ncs_rise", 32'(ncs_rise_cnt - d_nr), 32'(1));

    // miso stuck high, byte 00 out
    send(8'h00, 1'b1, 8'hFF);
    bus.iValid = 1'b0;
    wait_idle();
    chk("ff_odata", 32'(bus.oData), 32'(8'hFF));

    // 50-cycle pause inside a frame
    d_done = done_cnt;
    send(8'h3C, 1'b0, 8'h81);
    bus.iValid = 1'b0;
    r0 = 0;
    while (done_cnt == d_done && r0 < 500) begin
      @(posedge clk); #1;
      r0++;
    end
    ok = 0;
    repeat (50) begin
      @(negedge clk);
      if (ncs === 1'b0 && sck === 1'b0 && bus.oReady === 1'b1) ok++;
    end
    chk("wait50", 32'(ok), 32'(50));
    @(posedge clk); #1;
    send(8'hC3, 1'b1, 8'h7E);
    bus.iValid = 1'b0;
    wait_idle();
    chk("wait_odata", 32'(bus.oData), 32'(8'h7E));

    // next frame requested during the gap
    send(8'h11, 1'b1, 8'h22);
    send(8'h33, 1'b1, 8'h44);
    bus.iValid = 1'b0;
    wait_idle();
    chk("gap_hi", 32'(last_hi_run >= 4), 32'(1));
    chk("gap_odata", 32'(bus.oData), 32'(8'h44));

    // reset after the 4th rising sck edge
    d_done = done_cnt;
    send(8'h96, 1'b1, 8'h69);
    bus.iValid = 1'b0;
    r0 = rise_cnt;
    ok = 0;
    while (rise_cnt < r0 + 4 && ok < 500) begin
      @(negedge clk);
      ok++;
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ncs", 32'(ncs), 32'(1));
    chk("mid_rst_sck", 32'(sck), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_rst_nodone", 32'(done_cnt - d_done), 32'(0));
    loop_en = 1'b1;
    send(8'h5A, 1'b1, 8'h00);
    bus.iValid = 1'b0;
    wait_idle();
    loop_en = 1'b0;
    chk("post_rst_odata", 32'(bus.oData), 32'(8'h5A));

    // random frames with random pauses
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        send(8'($urandom), i == len - 1, 8'($urandom));
        if (i != len - 1 && $urandom_range(0, 1) == 1) begin
          bus.iValid = 1'b0;
          repeat ($urandom_range(1, 40)) @(posedge clk);
          #1;
        end
      end
      bus.iValid = 1'b0;
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_module.md
SPI_MASTER_MODULE -- requirements
Module: spi_master_module

Interface
REQ-001 Parameter SCK_HALF, default 4: sck half-period in clk cycles, legal range 1..255.
REQ-002 Parameter CS_SETUP, default 2: clk cycles from ncs falling to the first sck phase, legal range 1..255.
REQ-003 Parameter CS_HOLD, default 2: clk cycles from the last sck falling edge to ncs rising, legal range 1..255.
REQ-004 Parameter CS_GAP, default 4: clk cycles ncs stays high after a frame before a new frame may start, legal range 1..255.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 iValid  input  1  iData/iLast valid for transmission.
REQ-008 iData  input  8  byte to transmit, MSB first.
REQ-009 iLast  input  1  current byte ends the frame.
REQ-010 oReady  output  1  block accepts a byte this cycle.
REQ-011 oData  output  8  last byte received on miso.
REQ-012 oDone  output  1  one-cycle pulse when oData updates.
REQ-013 oBusy  output  1  high whenever state is not IDLE.
REQ-014 ncs  output  1  chip select to servo board, active-low.
REQ-015 sck  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-016 mosi  output  1  serial data out.
REQ-017 miso  input  1  serial data in, synchronised internally by a 2-flop synchroniser.

Function
REQ-018 States SHALL be IDLE, SETUP, SHIFT, WAIT, HOLD, GAP; oReady SHALL be 1 only in IDLE and WAIT.
REQ-019 A byte SHALL be accepted on a cycle with iValid=1 and oReady=1; iData and iLast are latched on that cycle.
REQ-020 IDLE + accept: next cycle ncs=0, mosi=iData[7], state SETUP for CS_SETUP cycles, then SHIFT.
REQ-021 SHIFT: each bit has a low phase of SCK_HALF cycles then a high phase of SCK_HALF cycles; a byte takes 16*SCK_HALF cycles.
REQ-022 miso (synchronised) SHALL be sampled in the cycle sck rises; mosi SHALL change to the next bit in the cycle sck falls, never while sck=1.
REQ-023 After the 8th high phase, sck returns to 0, oData takes the 8 sampled bits (first sampled = bit 7), and oDone pulses for one cycle.
REQ-024 Non-last byte: state WAIT, ncs stays 0, sck stays 0, mosi holds the last bit; WAIT has no timeout.
REQ-025 WAIT + accept: next cycle mosi=new iData[7] and state SHIFT (no SETUP delay).
REQ-026 Last byte: state HOLD for CS_HOLD cycles, then ncs=1 and state GAP for CS_GAP cycles, then IDLE.
REQ-027 iValid while oReady=0 SHALL be ignored, and the byte is not consumed.
REQ-028 oDone and acceptance of the next byte MAY coincide only in WAIT on the cycle after oDone; no byte is accepted in the oDone cycle itself.
REQ-029 Bit and phase counters SHALL wrap to 0 at the start of each byte; no state persists between frames except oData.

Reset
REQ-030 rst_n=0 SHALL force immediately: ncs=1, sck=0, mosi=0, oReady=0, oDone=0, oBusy=0, oData=8'h00, state IDLE, all counters 0.
REQ-031 Reset mid-frame SHALL discard the partial byte without an oDone pulse; after release the block enters IDLE with oReady=1 on the first clk edge.
REQ-032 No sck edge SHALL be generated while ncs=1.

Verification
REQ-033 SCK_HALF=2, CS_SETUP=2: single byte 8'hA5 with iLast=1, miso looped to mosi -> 8 sck pulses, mosi bits 1,0,1,0,0,1,0,1, oData=8'hA5, one oDone pulse, ncs low 2+32+2 cycles.
REQ-034 Frame of 13 bytes (8'h55 header plus 12 servo values 8'h00..8'h0B) sent back-to-back -> ncs stays low across all bytes, 13 oDone pulses, ncs rises once after the last byte.
REQ-035 miso held at 1 for byte 8'h00 -> oData=8'hFF and mosi=0 throughout; miso sampled only on sck rising edges.
REQ-036 iValid dropped for 50 cycles between bytes -> WAIT holds ncs=0, sck=0, and oReady=1 for all 50 cycles; the next byte starts without SETUP.
REQ-037 rst_n asserted after the 4th sck rising edge -> ncs=1, sck=0 in the same cycle, no oDone pulse; the next frame completes normally.
REQ-038 iValid asserted during GAP -> not accepted until CS_GAP=4 cycles have elapsed and IDLE is reached; ncs high time >= 4 cycles.
